// File: rtl/serial_frame_rx_if.sv
// serial_frame_rx_if: bundles the serial line inputs and the valid/ready word port
// of the framed serial receiver. The master modport is the receiver side.
interface serial_frame_rx_if #(
    parameter int WIDTH = 8
);
    logic             bit_en;
    logic             serial_in;
    logic             msb_first;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic             frame_err;
    logic             parity_err;
    logic             overrun;

    modport master (
        input  bit_en,
        input  serial_in,
        input  msb_first,
        input  dout_ready,
        output dout,
        output dout_valid,
        output busy,
        output frame_err,
        output parity_err,
        output overrun
    );

    modport slave (
        output bit_en,
        output serial_in,
        output msb_first,
        output dout_ready,
        input  dout,
        input  dout_valid,
        input  busy,
        input  frame_err,
        input  parity_err,
        input  overrun
    );
endinterface

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: framed serial-to-parallel receiver.
// Frame: start bit (0), WIDTH data bits (MSB- or LSB-first), optional even parity
// bit, stop bit (1). Defining SERIAL_FRAME_RX_PARITY_EN adds the parity bit and
// drives parity_err; otherwise parity_err is tied low.
module serial_frame_rx #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst,
    serial_frame_rx_if.master  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        STOP   = 2'd3
`ifdef SERIAL_FRAME_RX_PARITY_EN
        , PARITY = 2'd2
`endif
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shifter;
    logic             order_msb;
    logic             parity_bad;
    logic [WIDTH-1:0] dout_r;
    logic             dout_valid_r;
    logic             frame_err_r;
    logic             overrun_r;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic             parity_err_r;
`endif

    // Frame FSM, shifter and holding register; only strobed cycles advance the frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shifter      <= '0;
            order_msb    <= 1'b0;
            parity_bad   <= 1'b0;
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            parity_err_r <= 1'b0;
`endif
        end else begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            parity_err_r <= 1'b0;
`endif
            if (dout_valid_r && bus.dout_ready) begin
                dout_valid_r <= 1'b0;
            end
            if (bus.bit_en) begin
                case (state)
                    IDLE: begin
                        if (!bus.serial_in) begin
                            state      <= DATA;
                            bit_cnt    <= '0;
                            order_msb  <= bus.msb_first;
                            parity_bad <= 1'b0;
                        end
                    end
                    DATA: begin
                        if (order_msb) begin
                            shifter <= {shifter[WIDTH-2:0], bus.serial_in};
                        end else begin
                            shifter <= {bus.serial_in, shifter[WIDTH-1:1]};
                        end
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == CNT_W'(WIDTH - 1)) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
`ifdef SERIAL_FRAME_RX_PARITY_EN
                    PARITY: begin
                        if (bus.serial_in != (^shifter)) begin
                            parity_bad <= 1'b1;
                        end
                        state <= STOP;
                    end
`endif
                    STOP: begin
                        state       <= IDLE;
                        frame_err_r <= !bus.serial_in;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        parity_err_r <= parity_bad;
`endif
                        if (bus.serial_in && !parity_bad) begin
                            if (!dout_valid_r || bus.dout_ready) begin
                                dout_r       <= shifter;
                                dout_valid_r <= 1'b1;
                            end else begin
                                overrun_r <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.dout       = dout_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.busy       = (state != IDLE);
    assign bus.frame_err  = frame_err_r;
    assign bus.overrun    = overrun_r;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    assign bus.parity_err = parity_err_r;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Framed serial-to-parallel receiver. It samples one line bit per `bit_en` strobe and detects a start bit. It then assembles `WIDTH` data bits, MSB- or LSB-first, checks an optional even-parity bit and the stop bit. It presents the word on a valid/ready parallel port. It is the receiving end of the serial links driven by the team's shift-register transmitters, and sits between the line interface and word-level consumers.

## Interface
Parameters:
- `WIDTH`, default 8: data bits per frame, 2..32.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `bit_en`  in  1  bit strobe; `serial_in` is sampled only on cycles with `bit_en`=1.
- `serial_in`  in  1  serial line; idles high.
- `msb_first`  in  1  bit order.
  - 1: first data bit goes to `dout[WIDTH-1]`.
  - 0: first data bit goes to `dout[0]`.
  - Latched when the start bit is accepted.
- `dout`  out  WIDTH  received word; holding register.
- `dout_valid`  out  1  `dout` holds an unconsumed word.
- `dout_ready`  in  1  consumer accepts; transfer occurs when `dout_valid`&&`dout_ready`.
- `busy`  out  1  a frame is in progress (state ≠ IDLE).
- `frame_err`  out  1  one-cycle pulse: stop bit sampled as 0.
- `parity_err`  out  1  one-cycle pulse: parity mismatch. Tied 0 without the macro.
- `overrun`  out  1  one-cycle pulse: good frame completed while the holding register was full and not being read; the new word is dropped.

## Operation
- All sampling uses strobed cycles (`bit_en`=1) only; non-strobed cycles leave state, counters and shifter unchanged.
- FSM states: IDLE, DATA, PARITY (macro only), STOP.
  - IDLE: on a strobed 0, go to DATA, clear the bit counter and latch `msb_first`. On a strobed 1, stay in IDLE.
  - DATA: each strobe shifts `serial_in` into the shifter and increments the counter.
    - `msb_first`=1 shifts left, new bit entering at bit 0.
    - `msb_first`=0 shifts right, new bit entering at bit WIDTH-1.
    - After the WIDTH-th data bit, go to PARITY if the macro is defined, else STOP.
  - PARITY: one strobe. Compare `serial_in` with the XOR of the data bits; if they differ, set an internal parity-bad flag. Go to STOP.
  - STOP: one strobe, then IDLE.
    - Stop bit = 0: pulse `frame_err` and discard the word.
    - Otherwise, parity-bad set: pulse `parity_err` and discard the word.
    - Otherwise the frame is good.
    - If the stop bit is 0 and parity-bad is also set, both pulses fire in the same cycle.
- Good-frame delivery:
  - If `dout_valid`=0, or `dout_ready`=1 in the same cycle: load `dout`, and `dout_valid`=1 next cycle.
  - Otherwise: pulse `overrun`; `dout` and `dout_valid` are unchanged.
- Simultaneous read and delivery: the old word transfers and the new word loads; `dout_valid` stays 1.
- Read without delivery: `dout_valid` clears next cycle; `dout` keeps its stale value.
- A stop-bit strobe returns to IDLE. The earliest new start is the next strobe; no idle bit is required between frames.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `busy`=0, `frame_err`=0, `parity_err`=0, `overrun`=0; FSM in IDLE with counter, shifter and parity-bad cleared.
- Reset mid-frame aborts the frame silently; no error pulses.
- `busy` rises the cycle after the start-bit strobe and falls the cycle after the stop-bit strobe.
- `dout`/`dout_valid` update, and error pulses assert, on the clock edge that samples the stop bit, so they are visible the following cycle.
- Error pulses last exactly one clock cycle.
- Latency with `bit_en` tied high: WIDTH+2 cycles from start-bit sample to valid; WIDTH+3 with the macro.
- `dout_ready` has no effect while `dout_valid`=0.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SERIAL_FRAME_RX_PARITY_EN` defined:
  - The frame carries one even-parity bit after the data bits.
  - The PARITY state exists and `parity_err` is driven.
- `SERIAL_FRAME_RX_PARITY_EN` undefined:
  - No parity bit; the stop bit directly follows the data bits.
  - `parity_err` is tied 0 and the PARITY state is not built.

## Test plan
- WIDTH=8, `msb_first`=0, `bit_en`=1, macro off. Line 0,1,0,1,0,0,1,0,1,1 -> `dout`=0xA5, `dout_valid`=1 from cycle 10; no error pulses.
- Same data with `msb_first`=1 -> `dout`=0xA5 when the bits are sent 1,0,1,0,0,1,0,1 after the start bit. `bit_en` every 3rd cycle -> identical result, valid 1 cycle after the stop strobe.
- Stop bit 0 -> `frame_err` pulses once, `dout_valid` stays 0, FSM in IDLE.
  - Next frame 0x3C received correctly.
- Macro on: 0x0F with parity 1 -> `parity_err` pulse, word dropped. 0x0F with parity 0 -> `dout`=0x0F.
- Back-to-back frames 0x11 then 0x22 with `dout_ready`=0 -> 0x11 held, `overrun` pulses at the second stop.
  - Repeat with `dout_ready`=1 at the second delivery edge -> 0x11 transferred, `dout`=0x22, `dout_valid` stays 1.
- Assert `rst` after 4 data bits -> all outputs 0, no pulses. Then a full frame 0x81 -> `dout`=0x81.
